// File: rtl/trade_return_fanout.sv
// Engine-side result fan-out: every accepted word is copied into NUM_CH private FIFOs,
// and each FIFO is drained as a byte stream with valid/ready and word-boundary tlast.
module trade_return_fanout #(
  parameter int NUM_CH      = 2,
  parameter int WORD_W      = 32,
  parameter int DEPTH       = 16,
  parameter bit MSB_FIRST   = 1'b0,
  parameter bit FILTER_ZERO = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic [WORD_W-1:0]                      in_data,
  input  logic [NUM_CH-1:0]                      ch_enable,
  input  logic                                   clr_stats,
  output logic [NUM_CH*8-1:0]                    m_tdata,
  output logic [NUM_CH-1:0]                      m_tvalid,
  output logic [NUM_CH-1:0]                      m_tlast,
  input  logic [NUM_CH-1:0]                      m_tready,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    ch_level,
  output logic [NUM_CH*16-1:0]                   drop_count,
  output logic [NUM_CH-1:0]                      overflow_sticky
);

  localparam int BYTES = WORD_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // A zero word is a NOP only when filtering is enabled; it then never reaches any FIFO.
  logic w_word_ok;
  assign w_word_ok = in_valid && !(FILTER_ZERO && (in_data == '0));

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [WORD_W-1:0] r_mem [DEPTH];
      logic [AW-1:0]     r_wr_ptr;
      logic [AW-1:0]     r_rd_ptr;
      logic [CW-1:0]     r_count;
      logic [IW-1:0]     r_byte_idx;
      logic [15:0]       r_drop_cnt;
      logic              r_sticky;

      logic              w_empty;
      logic              w_full;
      logic              w_hs;
      logic              w_last;
      logic              w_pop;
      logic              w_wr_req;
      logic              w_wr_en;
      logic              w_drop;
      logic [WORD_W-1:0] w_head;
      logic [IW-1:0]     w_sel;
      logic [7:0]        w_byte;

      assign w_empty  = (r_count == '0);
      assign w_full   = (r_count == FULL_CNT);
      assign w_hs     = !w_empty && m_tready[c];
      assign w_last   = (r_byte_idx == LAST_IDX);
      assign w_pop    = w_hs && w_last;
      assign w_wr_req = w_word_ok && ch_enable[c];
      // A full channel still takes the word when its head leaves in the same cycle.
      assign w_wr_en  = w_wr_req && (!w_full || w_pop);
      assign w_drop   = w_wr_req && w_full && !w_pop;
      assign w_head   = r_mem[r_rd_ptr];

      always_comb begin
        w_sel  = MSB_FIRST ? IW'(LAST_IDX - r_byte_idx) : r_byte_idx;
        w_byte = w_head[{w_sel, 3'b000} +: 8];
      end

      // Storage has no reset; validity is carried entirely by r_count.
      always_ff @(posedge clk) begin
        if (w_wr_en) begin
          r_mem[r_wr_ptr] <= in_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_byte_idx <= '0;
        end else if (w_hs) begin
          r_byte_idx <= w_last ? '0 : r_byte_idx + IW'(1);
        end
      end

      // A drop coinciding with a clear is kept, so no loss goes unrecorded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_drop_cnt <= '0;
          r_sticky   <= 1'b0;
        end else if (clr_stats) begin
          r_drop_cnt <= {15'd0, w_drop};
          r_sticky   <= w_drop;
        end else if (w_drop) begin
          if (r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
          r_sticky <= 1'b1;
        end
      end

      assign m_tvalid[c]               = !w_empty;
      assign m_tdata[c*8 +: 8]         = w_empty ? 8'h00 : w_byte;
      assign m_tlast[c]                = !w_empty && w_last;
      assign ch_level[c*CW +: CW]      = r_count;
      assign drop_count[c*16 +: 16]    = r_drop_cnt;
      assign overflow_sticky[c]        = r_sticky;
    end
  endgenerate

endmodule

// File: tb/tb_trade_return_fanout.sv
// Directed bench for trade_return_fanout: an LSB-first unfiltered instance and an MSB-first
// zero-filtering instance share stimulus; a queue scoreboard predicts every byte and statistic.
module tb_trade_return_fanout;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  ch_enable;
  logic        clr_stats;
  logic [1:0]  tready;

  logic [15:0] tdata_o [2];
  logic [1:0]  tv_o    [2];
  logic [1:0]  tl_o    [2];
  logic [9:0]  lvl_o   [2];
  logic [31:0] dc_o    [2];
  logic [1:0]  st_o    [2];

  int n_cmp;
  int n_err;

  logic [31:0] mq [4][$];
  int          mi     [4];
  logic [15:0] mdrop  [4];
  bit          mst    [4];
  int          nbytes [4];

  trade_return_fanout #(
    .NUM_CH(2), .WORD_W(32), .DEPTH(16), .MSB_FIRST(1'b0), .FILTER_ZERO(1'b0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .ch_enable(ch_enable), .clr_stats(clr_stats),
    .m_tdata(tdata_o[0]), .m_tvalid(tv_o[0]), .m_tlast(tl_o[0]), .m_tready(tready),
    .ch_level(lvl_o[0]), .drop_count(dc_o[0]), .overflow_sticky(st_o[0])
  );

  trade_return_fanout #(
    .NUM_CH(2), .WORD_W(32), .DEPTH(16), .MSB_FIRST(1'b1), .FILTER_ZERO(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .ch_enable(ch_enable), .clr_stats(clr_stats),
    .m_tdata(tdata_o[1]), .m_tvalid(tv_o[1]), .m_tlast(tl_o[1]), .m_tready(tready),
    .ch_level(lvl_o[1]), .drop_count(dc_o[1]), .overflow_sticky(st_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
    logic [31:0] s;
    s = msb ? (w >> (8 * (3 - i))) : (w >> (8 * i));
    return s[7:0];
  endfunction

  // Scoreboard: compares the current cycle, then applies the upcoming edge to the model.
  always @(negedge clk) begin
    int   k;
    int   sz;
    bit   pop;
    bit   wr;
    bit   dn;
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        mq[j].delete();
        mi[j]    = 0;
        mdrop[j] = '0;
        mst[j]   = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          k  = d * 2 + c;
          sz = mq[k].size();
          check($sformatf("d%0d.c%0d.tvalid", d, c), 32'(tv_o[d][c]), 32'(sz != 0));
          if (sz != 0) begin
            check($sformatf("d%0d.c%0d.tdata", d, c), 32'(tdata_o[d][c*8 +: 8]),
                  32'(exp_byte(mq[k][0], mi[k], d == 1)));
            check($sformatf("d%0d.c%0d.tlast", d, c), 32'(tl_o[d][c]), 32'(mi[k] == 3));
          end else begin
            check($sformatf("d%0d.c%0d.tdata_idle", d, c), 32'(tdata_o[d][c*8 +: 8]), 32'd0);
            check($sformatf("d%0d.c%0d.tlast_idle", d, c), 32'(tl_o[d][c]), 32'd0);
          end
          check($sformatf("d%0d.c%0d.level", d, c), 32'(lvl_o[d][c*5 +: 5]), 32'(sz));
          check($sformatf("d%0d.c%0d.drops", d, c), 32'(dc_o[d][c*16 +: 16]), 32'(mdrop[k]));
          check($sformatf("d%0d.c%0d.sticky", d, c), 32'(st_o[d][c]), 32'(mst[k]));

          if (tv_o[d][c] && tready[c]) nbytes[k]++;

          pop = 1'b0;
          if (sz != 0 && tready[c]) begin
            if (mi[k] == 3) begin
              pop   = 1'b1;
              mi[k] = 0;
            end else begin
              mi[k]++;
            end
          end
          wr = in_valid && ch_enable[c] && !(d == 1 && in_data == 32'd0);
          dn = 1'b0;
          if (pop) void'(mq[k].pop_front());
          if (wr) begin
            if (sz == 16 && !pop) dn = 1'b1;
            else mq[k].push_back(in_data);
          end
          if (clr_stats) begin
            mdrop[k] = {15'd0, dn};
            mst[k]   = dn;
          end else if (dn) begin
            if (mdrop[k] != 16'hFFFF) mdrop[k] = mdrop[k] + 16'd1;
            mst[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic write_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drained(input bit only_ch1);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (only_ch1) done = (mq[1].size() == 0) && (mq[3].size() == 0);
      else done = (mq[0].size() == 0) && (mq[1].size() == 0) &&
                  (mq[2].size() == 0) && (mq[3].size() == 0);
      if (done) break;
      @(posedge clk); #1;
    end
    check("drain_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.d%0d.tvalid", tag, d), 32'(tv_o[d]), 32'd0);
      check($sformatf("%s.d%0d.tdata", tag, d), 32'(tdata_o[d]), 32'd0);
      check($sformatf("%s.d%0d.tlast", tag, d), 32'(tl_o[d]), 32'd0);
      check($sformatf("%s.d%0d.level", tag, d), 32'(lvl_o[d]), 32'd0);
      check($sformatf("%s.d%0d.drops", tag, d), dc_o[d], 32'd0);
      check($sformatf("%s.d%0d.sticky", tag, d), 32'(st_o[d]), 32'd0);
    end
  endtask

  initial begin
    int  b0;
    int  b1;
    int  b2;
    bit  hit;
    n_cmp     = 0;
    n_err     = 0;
    for (int j = 0; j < 4; j++) nbytes[j] = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_enable = 2'b11;
    clr_stats = 1'b0;
    tready    = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: one word, both channels ready; no combinational in_valid -> tvalid path
    in_valid = 1'b1;
    in_data  = 32'hA1B2C3D4;
    #1;
    check("t1.no_comb_path", 32'(tv_o[0]), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    check("t1.latency_d0", 32'(tv_o[0]), 32'h3);
    check("t1.latency_d1", 32'(tv_o[1]), 32'h3);
    check("t1.first_byte_d0", 32'(tdata_o[0]), 32'hD4D4);
    check("t1.first_byte_d1", 32'(tdata_o[1]), 32'hA1A1);
    wait_drained(1'b0);

    // T2: stall for 5 cycles after the first byte; byte and tlast must hold
    write_word(32'hA1B2C3D4);
    @(posedge clk); #1;
    tready = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check("t2.stall_d0", 32'(tdata_o[0]), 32'hC3C3);
    check("t2.stall_d1", 32'(tdata_o[1]), 32'hB2B2);
    check("t2.stall_tlast", 32'({tl_o[1], tl_o[0]}), 32'd0);
    tready = 2'b11;
    wait_drained(1'b0);

    // T3: only channel 0 enabled
    b0 = nbytes[0];
    b1 = nbytes[1];
    ch_enable = 2'b01;
    write_word(32'h11223344);
    write_word(32'h55667788);
    write_word(32'h99AABBCC);
    wait_drained(1'b0);
    check("t3.ch0_bytes", 32'(nbytes[0] - b0), 32'd12);
    check("t3.ch1_bytes", 32'(nbytes[1] - b1), 32'd0);
    check("t3.ch1_drops", 32'(dc_o[0][31:16]), 32'd0);
    ch_enable = 2'b11;

    // T4: channel 0 blocked, 20 back-to-back writes
    b1 = nbytes[1];
    tready = 2'b10;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000_0000 + 32'(i * 32'h0101_0101 + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("t4.level0", 32'(lvl_o[0][4:0]), 32'd16);
    check("t4.drops0", 32'(dc_o[0][15:0]), 32'd4);
    check("t4.sticky0", 32'(st_o[0][0]), 32'd1);
    wait_drained(1'b1);
    check("t4.ch1_bytes", 32'(nbytes[1] - b1), 32'd80);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    check("t4.clr_drops0", 32'(dc_o[0][15:0]), 32'd0);
    check("t4.clr_sticky0", 32'(st_o[0][0]), 32'd0);

    // T5: write into the full channel in the very cycle it pops
    tready = 2'b11;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (tv_o[0][0] && tl_o[0][0]) begin
        in_valid = 1'b1;
        in_data  = 32'hCAFE0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        hit = 1'b1;
        break;
      end
    end
    check("t5.pop_seen", 32'(hit), 32'd1);
    check("t5.level_full", 32'(lvl_o[0][4:0]), 32'd16);
    check("t5.no_drop", 32'(dc_o[0][15:0]), 32'd0);
    wait_drained(1'b0);

    // T6: zero word is a NOP only on the filtering instance
    b0 = nbytes[0];
    b2 = nbytes[2];
    write_word(32'h0000_0000);
    write_word(32'h0000_0001);
    wait_drained(1'b0);
    check("t6.unfiltered_bytes", 32'(nbytes[0] - b0), 32'd8);
    check("t6.filtered_bytes", 32'(nbytes[2] - b2), 32'd4);

    // Asynchronous reset in the middle of a word
    write_word(32'h5566_7788);
    @(posedge clk); #1;
    tready = 2'b00;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midword_reset");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    tready = 2'b11;
    @(posedge clk); #1;
    check("post_reset.tvalid", 32'({tv_o[1], tv_o[0]}), 32'd0);
    write_word(32'h0BAD_F00D);
    wait_drained(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
